branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution and redirect controller for the pipelined RV32I core. It sits at the EX stage and wraps the shared `cmp` comparator. It resolves conditional branches and jumps, trains a direct-mapped 2-bit branch history table (BHT) that serves fetch-stage direction predictions, and sequences the mispredict recovery: a redirect handshake to fetch, then a fixed-length front-end flush.

## Interface
Parameters:
- BHT_IDX_BITS, 6, log2 of BHT entries; index = pc[BHT_IDX_BITS+1:2]
- FLUSH_CYCLES, 2, flush cycles after redirect accept; legal range 1..15

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a control-flow instruction this cycle
- ex_is_br  in  1  conditional branch (uses ex_funct3)
- ex_is_jmp  in  1  jal/jalr, unconditionally taken; ex_is_br and ex_is_jmp are never both 1
- ex_funct3  in  branch_funct3_t  branch condition
- ex_rs1, ex_rs2  in  32  forwarded operands (rv32i_word)
- ex_pc, ex_target  in  32  instruction PC, computed taken target
- ex_pred_taken  in  1  prediction fetch made for this instruction
- if_pc  in  32  current fetch PC
- if_pred_taken  out  1  BHT prediction for if_pc (combinational read)
- redirect_valid  out  1  redirect_pc is valid for fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  32  corrected fetch PC
- flush  out  1  squash IF/ID contents
- stall_ex  out  1  hold EX and earlier stages
- br_count, mispred_count  out  32  resolved-instruction and mispredict statistics

## Operation
- Resolution, IDLE state only, on ex_valid:
  - actual_taken = ex_is_jmp ? 1 : br_en, where br_en comes from `cmp`.
  - Jumps are always treated as mispredicted.
  - Branches mispredict when actual_taken != ex_pred_taken.
  - Correct PC = actual_taken ? {ex_target[31:1],1'b0} : ex_pc + 4, with 32-bit wrap.
- BHT update: on ex_valid && ex_is_br in IDLE, the counter at ex_pc's index saturates toward the outcome (inc on taken, max 2'b11; dec on not taken, min 2'b00).
- if_pred_taken = bht[if_pc index][1]. A same-cycle read and write of one index returns the old value; there is no bypass.
- br_count increments on every ex_valid in IDLE. mispred_count increments on every mispredict. Both wrap at 2^32.
- FSM, state type brctl_state_t:
  - IDLE: on a mispredict, latch redirect_pc and go to REDIRECT. Otherwise stay.
  - REDIRECT: redirect_valid=1, flush=1, stall_ex=1. When redirect_ready=1, load flush_cnt=FLUSH_CYCLES-1 and go to FLUSH. redirect_pc is held stable until accepted.
  - FLUSH: flush=1. Decrement flush_cnt each cycle; go to IDLE in the cycle after flush_cnt==0.
- ex_valid in REDIRECT/FLUSH is wrong-path or stalled. It is ignored: no BHT update, no count.
- A correct prediction causes no state change and no output pulse.

## Timing
- Reset values: state IDLE; redirect_valid=0; flush=0; stall_ex=0; redirect_pc=0; counters=0; every BHT entry = 2'b01 (weakly not taken); flush_cnt=0.
- Reset asserted in any state returns immediately to IDLE with the values above. A pending redirect is dropped.
- Mispredict detected in cycle T → redirect_valid, flush and stall_ex all high from T+1. All are registered outputs, decoded from state.
- Redirect accepted in cycle A → flush high for cycles A+1..A+FLUSH_CYCLES, then IDLE. flush is continuously high from T+1 through A+FLUSH_CYCLES.
- redirect_ready held 1 constantly → minimum recovery of 1 + FLUSH_CYCLES cycles of non-IDLE.
- Back-to-back resolution is allowed: a new ex_valid is evaluated in the first IDLE cycle after FLUSH.

## Structure
- rv32i_types package: branch_funct3_t (existing), plus new brctl_state_t enum {IDLE, REDIRECT, FLUSH}.
- Sub-module: one instance of the existing `cmp` (cmpop=ex_funct3, rs1_out=ex_rs1, cmpmux_out=ex_rs2).
- BHT is a flop array of 2^BHT_IDX_BITS × 2 bits, reset in place. No SRAM macro.

## Test plan
- Reset: rst_n low mid-REDIRECT → next edge-free sample shows redirect_valid=0, flush=0; if_pred_taken=0 for any if_pc.
- beq with rs1=rs2=5, pred 0, ex_pc=0x100, target=0x180 → T+1 redirect_valid=1, redirect_pc=0x180. Accept at T+3 → flush high T+1..T+5; mispred_count=1.
- blt with rs1=0xFFFFFFFF, rs2=1, pred 1 → correct, no redirect, br_count=1. bltu with the same operands, pred 1 → redirect_pc=ex_pc+4.
- jalr with target=0x203, pred 1 → redirect_pc=0x202 (bit 0 cleared).
- BHT training: branch at pc 0x40 taken 3× then not taken 1× → counter goes 01→10→11→11→10, and if_pc=0x40 reads 1 throughout after the first update. Aliased pc 0x140 (BHT_IDX_BITS=6) reads the same entry.
- Boundary: ex_pc=0xFFFFFFFC not taken, pred 1 → redirect_pc=0x00000000. ex_valid during FLUSH → counters unchanged.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types: operand word, branch condition encoding and the
// branch-controller recovery state.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } brctl_state_t;

    // 2-bit saturating direction counter step.
    function automatic logic [1:0] bht_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Branch comparator shared with the EX stage: evaluates the funct3 condition
// between the forwarded rs1 and the rs2/immediate mux output.
module cmp
    import rv32i_types::*;
(
    input  branch_funct3_t cmpop,
    input  rv32i_word      rs1_out,
    input  rv32i_word      cmpmux_out,
    output logic           br_en
);

    always_comb begin
        br_en = 1'b0;
        case (cmpop)
            beq:     br_en = (rs1_out == cmpmux_out);
            bne:     br_en = (rs1_out != cmpmux_out);
            blt:     br_en = ($signed(rs1_out) < $signed(cmpmux_out));
            bge:     br_en = ($signed(rs1_out) >= $signed(cmpmux_out));
            bltu:    br_en = (rs1_out < cmpmux_out);
            bgeu:    br_en = (rs1_out >= cmpmux_out);
            default: br_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: resolves branches/jumps, trains a 2-bit BHT
// for fetch prediction and sequences redirect + fixed-length flush recovery.
module branch_ctrl
    import rv32i_types::*;
#(
    parameter int BHT_IDX_BITS = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ex_valid,
    input  logic           ex_is_br,
    input  logic           ex_is_jmp,
    input  branch_funct3_t ex_funct3,
    input  rv32i_word      ex_rs1,
    input  rv32i_word      ex_rs2,
    input  rv32i_word      ex_pc,
    input  rv32i_word      ex_target,
    input  logic           ex_pred_taken,
    input  rv32i_word      if_pc,
    output logic           if_pred_taken,
    output logic           redirect_valid,
    input  logic           redirect_ready,
    output rv32i_word      redirect_pc,
    output logic           flush,
    output logic           stall_ex,
    output logic [31:0]    br_count,
    output logic [31:0]    mispred_count,
    output brctl_state_t   dbg_state
);

    localparam int         BHT_ENTRIES = 1 << BHT_IDX_BITS;
    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

    brctl_state_t state_q, state_d;
    rv32i_word    redirect_pc_q, redirect_pc_d;
    logic [3:0]   flush_cnt_q, flush_cnt_d;
    logic [31:0]  br_count_q, br_count_d;
    logic [31:0]  mispred_count_q, mispred_count_d;
    logic [1:0]   bht_q [BHT_ENTRIES];

    logic                    br_en;
    logic                    actual_taken;
    logic                    mispred;
    rv32i_word               correct_pc;
    logic                    bht_we;
    logic [BHT_IDX_BITS-1:0] ex_idx;
    logic [BHT_IDX_BITS-1:0] if_idx;
    logic                    unused_pc_bits;

    cmp u_cmp (
        .cmpop      (ex_funct3),
        .rs1_out    (ex_rs1),
        .cmpmux_out (ex_rs2),
        .br_en      (br_en)
    );

    assign ex_idx         = ex_pc[BHT_IDX_BITS+1:2];
    assign if_idx         = if_pc[BHT_IDX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[31:BHT_IDX_BITS+2], if_pc[1:0], ex_target[0]};

    // Jumps always redirect: fetch never predicts their target.
    assign actual_taken = ex_is_jmp ? 1'b1 : br_en;
    assign mispred      = ex_is_jmp || (ex_is_br && (actual_taken != ex_pred_taken));
    assign correct_pc   = actual_taken ? {ex_target[31:1], 1'b0} : (ex_pc + 32'd4);

    // No bypass: a same-cycle update of if_pc's entry is seen next cycle.
    assign if_pred_taken = bht_q[if_idx][1];

    // Redirect handshake: redirect_pc is offered with redirect_valid=1 and held
    // unchanged until a cycle where redirect_ready=1; that cycle is the transfer.
    assign redirect_valid = (state_q == REDIRECT);
    assign stall_ex       = (state_q == REDIRECT);
    assign flush          = (state_q != IDLE);
    assign redirect_pc    = redirect_pc_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;
    assign dbg_state      = state_q;

    always_comb begin
        state_d         = state_q;
        redirect_pc_d   = redirect_pc_q;
        flush_cnt_d     = flush_cnt_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        bht_we          = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    br_count_d = br_count_q + 32'd1;
                    bht_we     = ex_is_br;
                    if (mispred) begin
                        mispred_count_d = mispred_count_q + 32'd1;
                        redirect_pc_d   = correct_pc;
                        state_d         = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            redirect_pc_q   <= '0;
            flush_cnt_q     <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            state_q         <= state_d;
            redirect_pc_q   <= redirect_pc_d;
            flush_cnt_q     <= flush_cnt_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
            if (bht_we) begin
                bht_q[ex_idx] <= bht_step(bht_q[ex_idx], actual_taken);
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: reset values, redirect/flush timing,
// BHT training and a table of resolution vectors.
module tb_branch_ctrl;
    import rv32i_types::*;

    logic           clk;
    logic           rst_n;
    logic           ex_valid;
    logic           ex_is_br;
    logic           ex_is_jmp;
    branch_funct3_t ex_funct3;
    rv32i_word      ex_rs1, ex_rs2, ex_pc, ex_target;
    logic           ex_pred_taken;
    rv32i_word      if_pc;
    logic           if_pred_taken;
    logic           redirect_valid;
    logic           redirect_ready;
    rv32i_word      redirect_pc;
    logic           flush;
    logic           stall_ex;
    logic [31:0]    br_count, mispred_count;
    brctl_state_t   dbg_state;

    int n_checks;
    int n_fail;
    logic [31:0] exp_br;
    logic [31:0] exp_mp;

    typedef struct {
        logic           is_br;
        logic           is_jmp;
        branch_funct3_t f3;
        logic [31:0]    rs1;
        logic [31:0]    rs2;
        logic [31:0]    pc;
        logic [31:0]    tgt;
        logic           pred;
        logic           exp_mis;
        logic [31:0]    exp_rpc;
    } vec_t;

    vec_t vecs[9];

    branch_ctrl #(.BHT_IDX_BITS(6), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_is_jmp      (ex_is_jmp),
        .ex_funct3      (ex_funct3),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .stall_ex       (stall_ex),
        .br_count       (br_count),
        .mispred_count  (mispred_count),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic is_br, input logic is_jmp, input branch_funct3_t f3,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        ex_valid      = 1'b1;
        ex_is_br      = is_br;
        ex_is_jmp     = is_jmp;
        ex_funct3     = f3;
        ex_rs1        = rs1;
        ex_rs2        = rs2;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
    endtask

    task automatic idle_ex();
        ex_valid  = 1'b0;
        ex_is_br  = 1'b0;
        ex_is_jmp = 1'b0;
    endtask

    task automatic recover(input string name);
        redirect_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (dbg_state == IDLE) break;
            step();
        end
        redirect_ready = 1'b0;
        check({name, "_recover_idle"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_br   = 0;
        exp_mp   = 0;

        vecs[0] = '{1'b1, 1'b0, beq,  32'd5,        32'd5,        32'h0000_0100, 32'h0000_0180, 1'b0, 1'b1, 32'h0000_0180};
        vecs[1] = '{1'b1, 1'b0, blt,  32'hFFFF_FFFF, 32'd1,       32'h0000_0104, 32'h0000_0190, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, bltu, 32'hFFFF_FFFF, 32'd1,       32'h0000_0108, 32'h0000_01F0, 1'b1, 1'b1, 32'h0000_010C};
        vecs[3] = '{1'b0, 1'b1, beq,  32'd0,        32'd0,        32'h0000_0110, 32'h0000_0203, 1'b1, 1'b1, 32'h0000_0202};
        vecs[4] = '{1'b1, 1'b0, bne,  32'd3,        32'd3,        32'hFFFF_FFFC, 32'h0000_0800, 1'b1, 1'b1, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, bge,  32'd1,        32'hFFFF_FFFF, 32'h0000_0120, 32'h0000_0300, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, bgeu, 32'd1,        32'hFFFF_FFFF, 32'h0000_0124, 32'h0000_0400, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, bne,  32'd1,        32'd2,        32'h0000_0128, 32'h0000_0501, 1'b0, 1'b1, 32'h0000_0500};
        vecs[8] = '{1'b1, 1'b0, beq,  32'd7,        32'd8,        32'h0000_012C, 32'h0000_0600, 1'b0, 1'b0, 32'h0};

        rst_n          = 1'b0;
        redirect_ready = 1'b0;
        if_pc          = 32'h0;
        ex_funct3      = beq;
        ex_rs1         = '0;
        ex_rs2         = '0;
        ex_pc          = '0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        idle_ex();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();

        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_stall_ex", 32'(stall_ex), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_br_count", br_count, 32'd0);
        check("rst_mispred_count", mispred_count, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        if_pc = 32'h0000_0000; #1;
        check("rst_pred_0", 32'(if_pred_taken), 32'd0);
        if_pc = 32'h0000_00FC; #1;
        check("rst_pred_fc", 32'(if_pred_taken), 32'd0);

        // Mispredicted beq, redirect accepted in T+3, wrong-path ex_valid in FLUSH.
        drive_ex(1'b1, 1'b0, beq, 32'd5, 32'd5, 32'h100, 32'h180, 1'b0);
        step();
        idle_ex();
        exp_br++; exp_mp++;
        check("a_t1_redirect_valid", 32'(redirect_valid), 32'd1);
        check("a_t1_flush", 32'(flush), 32'd1);
        check("a_t1_stall", 32'(stall_ex), 32'd1);
        check("a_t1_redirect_pc", redirect_pc, 32'h180);
        check("a_t1_mispred", mispred_count, exp_mp);
        step();
        check("a_t2_redirect_valid", 32'(redirect_valid), 32'd1);
        check("a_t2_redirect_pc_hold", redirect_pc, 32'h180);
        check("a_t2_flush", 32'(flush), 32'd1);
        step();
        check("a_t3_redirect_valid", 32'(redirect_valid), 32'd1);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check("a_t4_redirect_valid", 32'(redirect_valid), 32'd0);
        check("a_t4_flush", 32'(flush), 32'd1);
        check("a_t4_stall", 32'(stall_ex), 32'd0);
        drive_ex(1'b1, 1'b0, bne, 32'd5, 32'd5, 32'h100, 32'h180, 1'b1);
        step();
        idle_ex();
        check("a_t5_flush", 32'(flush), 32'd1);
        check("a_t5_br_count", br_count, exp_br);
        check("a_t5_mispred", mispred_count, exp_mp);
        step();
        check("a_t6_flush", 32'(flush), 32'd0);
        check("a_t6_state", 32'(dbg_state), 32'(IDLE));
        check("a_t6_br_count", br_count, exp_br);
        if_pc = 32'h100; #1;
        check("a_bht_0x100", 32'(if_pred_taken), 32'd1);

        // BHT training at pc 0x40: taken x3, then not taken x2.
        if_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 1'b0, beq, 32'd5, 32'd5, 32'h40, 32'h80, 1'b1);
            #1;
            if (i == 0) check("b_same_cycle_old", 32'(if_pred_taken), 32'd0);
            step();
            idle_ex();
            exp_br++;
            check($sformatf("b_taken%0d_pred", i), 32'(if_pred_taken), 32'd1);
            check($sformatf("b_taken%0d_redirect", i), 32'(redirect_valid), 32'd0);
        end
        drive_ex(1'b1, 1'b0, beq, 32'd5, 32'd6, 32'h40, 32'h80, 1'b0);
        step();
        idle_ex();
        exp_br++;
        check("b_nt1_pred", 32'(if_pred_taken), 32'd1);
        if_pc = 32'h140; #1;
        check("b_alias_0x140", 32'(if_pred_taken), 32'd1);
        check("b_br_count", br_count, exp_br);
        check("b_mispred", mispred_count, exp_mp);
        if_pc = 32'h40;
        drive_ex(1'b1, 1'b0, beq, 32'd5, 32'd6, 32'h40, 32'h80, 1'b0);
        step();
        idle_ex();
        exp_br++;
        check("b_nt2_pred", 32'(if_pred_taken), 32'd0);

        // Table of resolution vectors.
        for (int v = 0; v < 9; v++) begin
            drive_ex(vecs[v].is_br, vecs[v].is_jmp, vecs[v].f3, vecs[v].rs1, vecs[v].rs2,
                     vecs[v].pc, vecs[v].tgt, vecs[v].pred);
            step();
            idle_ex();
            exp_br++;
            if (vecs[v].exp_mis) exp_mp++;
            check($sformatf("v%0d_redirect_valid", v), 32'(redirect_valid), 32'(vecs[v].exp_mis));
            check($sformatf("v%0d_flush", v), 32'(flush), 32'(vecs[v].exp_mis));
            if (vecs[v].exp_mis) check($sformatf("v%0d_redirect_pc", v), redirect_pc, vecs[v].exp_rpc);
            check($sformatf("v%0d_br_count", v), br_count, exp_br);
            check($sformatf("v%0d_mispred", v), mispred_count, exp_mp);
            if (redirect_valid || flush) recover($sformatf("v%0d", v));
        end

        // Reset asserted mid-REDIRECT drops the pending redirect.
        drive_ex(1'b0, 1'b1, beq, 32'd0, 32'd0, 32'h300, 32'h700, 1'b1);
        step();
        idle_ex();
        check("c_pre_redirect_valid", 32'(redirect_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("c_rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("c_rst_flush", 32'(flush), 32'd0);
        check("c_rst_redirect_pc", redirect_pc, 32'd0);
        check("c_rst_br_count", br_count, 32'd0);
        if_pc = 32'h100; #1;
        check("c_rst_pred_0x100", 32'(if_pred_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("c_post_state", 32'(dbg_state), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
